// File: rtl/instr_encoder_if.sv
// Request/response bundle for instr_encoder: mnemonic request in, encoded instruction word out.
// The slave modport is the encoder's view; master is the producer/consumer side.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_instr
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_instr
    );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: turns (op, rd, rs1, rs2, imm) requests into RV32IM words, queued in a DEPTH-entry FIFO.
// Optional macro INSTR_ENCODER_RANGE_CHECK_EN replaces out-of-range immediates with a NOP and flags err_range.
module instr_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    instr_encoder_if.slave   bus,
    output logic [CNT_W-1:0] enc_count,
    output logic             err_illegal,
    output logic             err_range
);
    localparam int             PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [31:0]    NOP      = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_J, FMT_U, FMT_ILL
    } fmt_e;

    fmt_e        w_fmt;
    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm;
    logic [31:0] w_raw;
    logic [31:0] w_word;
    logic        w_illegal;
    logic        w_range_bad;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic        w_out_valid;

    logic [31:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [CNT_W-1:0] r_enc_count;
    logic             r_err_illegal;

    assign w_imm = bus.in_imm;

    // NOTE: every combinational output gets a default before the case, so no path leaves a latch behind.
    always_comb begin
        w_fmt = FMT_ILL;
        w_opc = 7'h13;
        w_f3  = 3'd0;
        w_f7  = 7'h00;
        case (bus.in_op)
            6'd0:  begin w_fmt = FMT_R;  w_opc = 7'h33; w_f3 = 3'd0; end
            6'd1:  begin w_fmt = FMT_R;  w_opc = 7'h33; w_f3 = 3'd0; w_f7 = 7'h20; end
            6'd2:  begin w_fmt = FMT_R;  w_opc = 7'h33; w_f3 = 3'd7; end
            6'd3:  begin w_fmt = FMT_R;  w_opc = 7'h33; w_f3 = 3'd6; end
            6'd4:  begin w_fmt = FMT_R;  w_opc = 7'h33; w_f3 = 3'd4; end
            6'd5:  begin w_fmt = FMT_R;  w_opc = 7'h33; w_f3 = 3'd1; end
            6'd6:  begin w_fmt = FMT_R;  w_opc = 7'h33; w_f3 = 3'd5; end
            6'd7:  begin w_fmt = FMT_R;  w_opc = 7'h33; w_f3 = 3'd5; w_f7 = 7'h20; end
            6'd8:  begin w_fmt = FMT_R;  w_opc = 7'h33; w_f3 = 3'd2; end
            6'd9:  begin w_fmt = FMT_R;  w_opc = 7'h33; w_f3 = 3'd3; end
            6'd10: begin w_fmt = FMT_R;  w_opc = 7'h33; w_f3 = 3'd0; w_f7 = 7'h01; end
            6'd11: begin w_fmt = FMT_R;  w_opc = 7'h33; w_f3 = 3'd1; w_f7 = 7'h01; end
            6'd12: begin w_fmt = FMT_R;  w_opc = 7'h33; w_f3 = 3'd4; w_f7 = 7'h01; end
            6'd13: begin w_fmt = FMT_R;  w_opc = 7'h33; w_f3 = 3'd5; w_f7 = 7'h01; end
            6'd14: begin w_fmt = FMT_R;  w_opc = 7'h33; w_f3 = 3'd6; w_f7 = 7'h01; end
            6'd15: begin w_fmt = FMT_R;  w_opc = 7'h33; w_f3 = 3'd7; w_f7 = 7'h01; end
            6'd16: begin w_fmt = FMT_I;  w_opc = 7'h13; w_f3 = 3'd0; end
            6'd17: begin w_fmt = FMT_I;  w_opc = 7'h13; w_f3 = 3'd7; end
            6'd18: begin w_fmt = FMT_I;  w_opc = 7'h13; w_f3 = 3'd6; end
            6'd19: begin w_fmt = FMT_I;  w_opc = 7'h13; w_f3 = 3'd4; end
            6'd20: begin w_fmt = FMT_I;  w_opc = 7'h13; w_f3 = 3'd2; end
            6'd21: begin w_fmt = FMT_I;  w_opc = 7'h13; w_f3 = 3'd3; end
            6'd22: begin w_fmt = FMT_SH; w_opc = 7'h13; w_f3 = 3'd1; end
            6'd23: begin w_fmt = FMT_SH; w_opc = 7'h13; w_f3 = 3'd5; end
            6'd24: begin w_fmt = FMT_SH; w_opc = 7'h13; w_f3 = 3'd5; w_f7 = 7'h20; end
            6'd25: begin w_fmt = FMT_I;  w_opc = 7'h03; w_f3 = 3'd0; end
            6'd26: begin w_fmt = FMT_I;  w_opc = 7'h03; w_f3 = 3'd1; end
            6'd27: begin w_fmt = FMT_I;  w_opc = 7'h03; w_f3 = 3'd2; end
            6'd28: begin w_fmt = FMT_I;  w_opc = 7'h03; w_f3 = 3'd4; end
            6'd29: begin w_fmt = FMT_I;  w_opc = 7'h03; w_f3 = 3'd5; end
            6'd30: begin w_fmt = FMT_S;  w_opc = 7'h23; w_f3 = 3'd0; end
            6'd31: begin w_fmt = FMT_S;  w_opc = 7'h23; w_f3 = 3'd1; end
            6'd32: begin w_fmt = FMT_S;  w_opc = 7'h23; w_f3 = 3'd2; end
            6'd33: begin w_fmt = FMT_B;  w_opc = 7'h63; w_f3 = 3'd0; end
            6'd34: begin w_fmt = FMT_B;  w_opc = 7'h63; w_f3 = 3'd1; end
            6'd35: begin w_fmt = FMT_B;  w_opc = 7'h63; w_f3 = 3'd4; end
            6'd36: begin w_fmt = FMT_B;  w_opc = 7'h63; w_f3 = 3'd5; end
            6'd37: begin w_fmt = FMT_B;  w_opc = 7'h63; w_f3 = 3'd6; end
            6'd38: begin w_fmt = FMT_B;  w_opc = 7'h63; w_f3 = 3'd7; end
            6'd39: begin w_fmt = FMT_J;  w_opc = 7'h6F; end
            6'd40: begin w_fmt = FMT_I;  w_opc = 7'h67; w_f3 = 3'd0; end
            6'd41: begin w_fmt = FMT_U;  w_opc = 7'h37; end
            6'd42: begin w_fmt = FMT_U;  w_opc = 7'h17; end
            default: ;
        endcase
    end

    assign w_illegal = (w_fmt == FMT_ILL);

    always_comb begin
        w_raw = NOP;
        case (w_fmt)
            FMT_R:  w_raw = {w_f7, bus.in_rs2, bus.in_rs1, w_f3, bus.in_rd, w_opc};
            FMT_I:  w_raw = {w_imm[11:0], bus.in_rs1, w_f3, bus.in_rd, w_opc};
            FMT_SH: w_raw = {w_f7, w_imm[4:0], bus.in_rs1, w_f3, bus.in_rd, w_opc};
            FMT_S:  w_raw = {w_imm[11:5], bus.in_rs2, bus.in_rs1, w_f3, w_imm[4:0], w_opc};
            FMT_B:  w_raw = {w_imm[12], w_imm[10:5], bus.in_rs2, bus.in_rs1, w_f3,
                             w_imm[4:1], w_imm[11], w_opc};
            FMT_J:  w_raw = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], bus.in_rd, w_opc};
            FMT_U:  w_raw = {w_imm[31:12], bus.in_rd, w_opc};
            default: w_raw = NOP;
        endcase
    end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    // A field "fits" when every bit above it equals its sign bit.
    always_comb begin
        w_range_bad = 1'b0;
        case (w_fmt)
            FMT_I, FMT_S: w_range_bad = !((&w_imm[31:11]) || !(|w_imm[31:11]));
            FMT_B:        w_range_bad = !((&w_imm[31:12]) || !(|w_imm[31:12])) || w_imm[0];
            FMT_J:        w_range_bad = !((&w_imm[31:20]) || !(|w_imm[31:20])) || w_imm[0];
            FMT_SH:       w_range_bad = |w_imm[31:5];
            FMT_U:        w_range_bad = |w_imm[11:0];
            default:      w_range_bad = 1'b0;
        endcase
    end
`else
    assign w_range_bad = 1'b0;
`endif

    assign w_word = w_range_bad ? NOP : w_raw;

    assign w_full       = (r_count == FULL_CNT);
    assign w_out_valid  = (r_count != '0);
    assign bus.in_ready = !reset && !flush && !w_full;
    assign w_push       = bus.in_valid && bus.in_ready;
    assign w_pop        = w_out_valid && bus.out_ready && !flush;
    assign bus.out_valid = w_out_valid;
    assign bus.out_instr = w_out_valid ? r_mem[r_rd_ptr] : '0;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is left unreset; out_instr is masked to 0 while the FIFO is empty instead.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_enc_count   <= '0;
            r_err_illegal <= 1'b0;
        end else begin
            if (w_push) r_enc_count <= r_enc_count + CNT_W'(1);
            if (flush)
                r_err_illegal <= 1'b0;
            else if (w_push && w_illegal)
                r_err_illegal <= 1'b1;
        end
    end

    assign enc_count   = r_enc_count;
    assign err_illegal = r_err_illegal;

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    logic r_err_range;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_err_range <= 1'b0;
        else if (flush)
            r_err_range <= 1'b0;
        else if (w_push && w_range_bad)
            r_err_range <= 1'b1;
    end

    assign err_range = r_err_range;
`else
    assign err_range = 1'b0;
`endif
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed encodings, backpressure, flush, resets and
// randomized traffic scored against a queue-based reference model.
module tb_instr_encoder;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] enc_count;
    logic        err_illegal;
    logic        err_range;

    instr_encoder_if bus();

    instr_encoder #(.DEPTH(DEPTH), .CNT_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .bus         (bus),
        .enc_count   (enc_count),
        .err_illegal (err_illegal),
        .err_range   (err_range)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_cnt  = '0;
    bit          exp_ill  = 1'b0;
    bit          exp_rng  = 1'b0;

    // Reference encoding built from the ISA field layout with plain shifts and masks.
    function automatic logic [31:0] model_word(input int op, input int rd, input int rs1, input int rs2,
                                               input logic [31:0] imm, output bit ill, output bit rng);
        int r_f3[16];
        int i_f3[6];
        int sh_f3[3];
        int ld_f3[5];
        int st_f3[3];
        int br_f3[6];
        logic [31:0] w, f7, d, s1, s2;
        int s;
        r_f3  = '{0, 0, 7, 6, 4, 1, 5, 5, 2, 3, 0, 1, 4, 5, 6, 7};
        i_f3  = '{0, 7, 6, 4, 2, 3};
        sh_f3 = '{1, 5, 5};
        ld_f3 = '{0, 1, 2, 4, 5};
        st_f3 = '{0, 1, 2};
        br_f3 = '{0, 1, 4, 5, 6, 7};
        d   = 32'(rd) << 7;
        s1  = 32'(rs1) << 15;
        s2  = 32'(rs2) << 20;
        s   = int'($signed(imm));
        ill = 1'b0;
        rng = 1'b0;
        if (op <= 15) begin
            f7 = (op == 1 || op == 7) ? 32'h20 : ((op >= 10) ? 32'h01 : 32'h00);
            w  = (f7 << 25) | s2 | s1 | (32'(r_f3[op]) << 12) | d | 32'h33;
        end else if (op <= 21) begin
            w   = ((imm & 32'hFFF) << 20) | s1 | (32'(i_f3[op-16]) << 12) | d | 32'h13;
            rng = (s < -2048) || (s > 2047);
        end else if (op <= 24) begin
            f7  = (op == 24) ? 32'h20 : 32'h00;
            w   = (f7 << 25) | ((imm & 32'h1F) << 20) | s1 | (32'(sh_f3[op-22]) << 12) | d | 32'h13;
            rng = imm > 32'd31;
        end else if (op <= 29) begin
            w   = ((imm & 32'hFFF) << 20) | s1 | (32'(ld_f3[op-25]) << 12) | d | 32'h03;
            rng = (s < -2048) || (s > 2047);
        end else if (op <= 32) begin
            w   = (((imm >> 5) & 32'h7F) << 25) | s2 | s1 | (32'(st_f3[op-30]) << 12)
                | ((imm & 32'h1F) << 7) | 32'h23;
            rng = (s < -2048) || (s > 2047);
        end else if (op <= 38) begin
            w   = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | s2 | s1
                | (32'(br_f3[op-33]) << 12) | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'h63;
            rng = (s < -4096) || (s > 4095) || imm[0];
        end else if (op == 39) begin
            w   = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | d | 32'h6F;
            rng = (s < -1048576) || (s > 1048575) || imm[0];
        end else if (op == 40) begin
            w   = ((imm & 32'hFFF) << 20) | s1 | d | 32'h67;
            rng = (s < -2048) || (s > 2047);
        end else if (op == 41 || op == 42) begin
            w   = (imm & 32'hFFFF_F000) | d | ((op == 41) ? 32'h37 : 32'h17);
            rng = (imm & 32'hFFF) != 0;
        end else begin
            w   = NOP;
            ill = 1'b1;
        end
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        if (rng) w = NOP;
`else
        rng = 1'b0;
`endif
        return w;
    endfunction

    task automatic drive(input bit v, input int op, input int rd, input int rs1, input int rs2,
                         input logic [31:0] imm, input bit ordy);
        bus.in_valid  = v;
        bus.in_op     = 6'(op);
        bus.in_rd     = 5'(rd);
        bus.in_rs1    = 5'(rs1);
        bus.in_rs2    = 5'(rs2);
        bus.in_imm    = imm;
        bus.out_ready = ordy;
        #1;
    endtask

    // Advances one clock and applies the model's view of that edge.
    task automatic tick();
        bit acc, pop, fl, ill, rng;
        logic [31:0] w;
        fl  = flush;
        acc = bus.in_valid && !fl && (exp_q.size() < DEPTH);
        pop = bus.out_ready && (exp_q.size() > 0) && !fl;
        w   = model_word(int'(bus.in_op), int'(bus.in_rd), int'(bus.in_rs1), int'(bus.in_rs2),
                         bus.in_imm, ill, rng);
        @(posedge clk);
        #1;
        if (fl) begin
            exp_q.delete();
            exp_ill = 1'b0;
            exp_rng = 1'b0;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (acc) begin
                exp_q.push_back(w);
                exp_cnt = exp_cnt + 32'd1;
                if (ill) exp_ill = 1'b1;
                if (rng) exp_rng = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 32'h0, 0);
        n_assert++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        n_assert++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_assert++; if (bus.out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_out_instr: got %h want 0", bus.out_instr); end
        n_assert++; if (enc_count !== 32'h0) begin n_fail++; $display("FAIL reset_enc_count: got %0d want 0", enc_count); end
        n_assert++; if (err_illegal !== 1'b0 || err_range !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b%b want 00", err_illegal, err_range); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        n_assert++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_vectors();
        int          ops[5];
        int          rds[5];
        int          r1s[5];
        int          r2s[5];
        logic [31:0] imms[5];
        logic [31:0] want[5];
        ops  = '{0, 16, 32, 33, 24};
        rds  = '{3, 1, 0, 0, 4};
        r1s  = '{1, 0, 2, 0, 4};
        r2s  = '{2, 0, 5, 0, 0};
        imms = '{32'h0, 32'hFFFF_FFFF, 32'h8, 32'hFFFF_FFFC, 32'h3};
        want = '{32'h002081B3, 32'hFFF00093, 32'h00512423, 32'hFE000EE3, 32'h40325213};
        for (int i = 0; i < 5; i++) begin
            drive(1, ops[i], rds[i], r1s[i], r2s[i], imms[i], 0);
            tick();
            drive(0, 0, 0, 0, 0, 32'h0, 0);
            n_assert++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL vec%0d_latency: out_valid %b want 1", i, bus.out_valid); end
            n_assert++; if (bus.out_instr !== want[i]) begin n_fail++; $display("FAIL vec%0d_word: got %h want %h", i, bus.out_instr, want[i]); end
            drive(0, 0, 0, 0, 0, 32'h0, 1);
            tick();
        end
        n_assert++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL vec_drained: out_valid %b want 0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] start;
        start = exp_cnt;
        for (int i = 0; i < 5; i++) begin
            drive(1, 16, i + 1, i, 0, 32'(i * 8 + 100), 0);
            n_assert++; if (bus.in_ready !== (i < 4)) begin n_fail++; $display("FAIL bp_in_ready%0d: got %b want %b", i, bus.in_ready, (i < 4)); end
            tick();
        end
        drive(1, 16, 5, 4, 0, 32'(4 * 8 + 100), 1);
        for (int k = 0; k < 12 && exp_q.size() > 0; k++) begin
            n_assert++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid%0d: got %b want 1", k, bus.out_valid); end
            n_assert++; if (bus.out_instr !== exp_q[0]) begin n_fail++; $display("FAIL bp_order%0d: got %h want %h", k, bus.out_instr, exp_q[0]); end
            tick();
            if (exp_cnt == start + 32'd5) drive(0, 0, 0, 0, 0, 32'h0, 1);
            else                         drive(1, 16, 5, 4, 0, 32'(4 * 8 + 100), 1);
        end
        n_assert++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: out_valid %b want 0", bus.out_valid); end
        n_assert++; if (enc_count !== start + 32'd5) begin n_fail++; $display("FAIL bp_enc_count: got %0d want %0d", enc_count, start + 32'd5); end
    endtask

    task automatic test_illegal_flush();
        logic [31:0] cnt_before;
        drive(1, 63, 7, 7, 7, 32'h1234, 0);
        tick();
        drive(0, 0, 0, 0, 0, 32'h0, 0);
        n_assert++; if (bus.out_instr !== NOP) begin n_fail++; $display("FAIL illegal_word: got %h want %h", bus.out_instr, NOP); end
        n_assert++; if (err_illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_flag: got %b want 1", err_illegal); end
        tick();
        tick();
        n_assert++; if (err_illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_sticky: got %b want 1", err_illegal); end
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        drive(1, 16, 1, 0, 0, 32'd4096, 0);
        tick();
        drive(0, 0, 0, 0, 0, 32'h0, 0);
        n_assert++; if (err_range !== 1'b1) begin n_fail++; $display("FAIL range_flag: got %b want 1", err_range); end
        n_assert++; if (bus.out_instr !== NOP || exp_q.size() != 2) begin n_fail++; $display("FAIL range_word: got %h want %h", bus.out_instr, NOP); end
`else
        drive(1, 16, 1, 0, 0, 32'd4096, 1);
        tick();
        drive(0, 0, 0, 0, 0, 32'h0, 0);
        n_assert++; if (bus.out_instr !== 32'h0000_0093) begin n_fail++; $display("FAIL trunc_word: got %h want 00000093", bus.out_instr); end
        n_assert++; if (err_range !== 1'b0) begin n_fail++; $display("FAIL range_tied: got %b want 0", err_range); end
`endif
        cnt_before = exp_cnt;
        flush = 1'b1;
        drive(1, 0, 1, 1, 1, 32'h0, 0);
        n_assert++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b want 0", bus.in_ready); end
        tick();
        flush = 1'b0;
        drive(0, 0, 0, 0, 0, 32'h0, 0);
        n_assert++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty: out_valid %b want 0", bus.out_valid); end
        n_assert++; if (err_illegal !== 1'b0 || err_range !== 1'b0) begin n_fail++; $display("FAIL flush_err: got %b%b want 00", err_illegal, err_range); end
        n_assert++; if (enc_count !== cnt_before) begin n_fail++; $display("FAIL flush_count: got %0d want %0d", enc_count, cnt_before); end
    endtask

    task automatic test_random();
        int          op;
        logic [31:0] imm;
        for (int c = 0; c < 400; c++) begin
            op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(43, 63)) : int'($urandom_range(0, 42));
            case ($urandom_range(0, 3))
                0:       imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                1:       imm = (32'($urandom_range(0, 8191)) - 32'd4096) & 32'hFFFF_FFFE;
                2:       imm = $urandom;
                default: imm = $urandom & 32'hFFFF_F000;
            endcase
            flush = ($urandom_range(0, 99) < 3);
            drive($urandom_range(0, 3) != 0, op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)), imm, $urandom_range(0, 2) != 0);
            n_assert++; if (bus.in_ready !== (!flush && exp_q.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_in_ready@%0d: got %b want %b", c, bus.in_ready, (!flush && exp_q.size() < DEPTH)); end
            n_assert++; if (bus.out_valid !== (exp_q.size() > 0)) begin n_fail++; $display("FAIL rnd_out_valid@%0d: got %b want %b", c, bus.out_valid, (exp_q.size() > 0)); end
            if (exp_q.size() > 0) begin
                n_assert++; if (bus.out_instr !== exp_q[0]) begin n_fail++; $display("FAIL rnd_word@%0d: got %h want %h", c, bus.out_instr, exp_q[0]); end
            end
            n_assert++; if (enc_count !== exp_cnt) begin n_fail++; $display("FAIL rnd_count@%0d: got %0d want %0d", c, enc_count, exp_cnt); end
            n_assert++; if (err_illegal !== exp_ill || err_range !== exp_rng) begin n_fail++; $display("FAIL rnd_err@%0d: got %b%b want %b%b", c, err_illegal, err_range, exp_ill, exp_rng); end
            tick();
        end
        flush = 1'b0;
    endtask

    task automatic test_reset_midburst();
        flush = 1'b1;
        drive(0, 0, 0, 0, 0, 32'h0, 0);
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 4, i, i + 1, i + 2, 32'h0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 32'h0, 0);
        n_assert++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_queued: out_valid %b want 1", bus.out_valid); end
        #2;
        reset = 1'b1;
        #1;
        exp_q.delete();
        exp_cnt = '0;
        exp_ill = 1'b0;
        exp_rng = 1'b0;
        n_assert++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b want 0", bus.out_valid); end
        n_assert++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_in_ready: got %b want 0", bus.in_ready); end
        n_assert++; if (enc_count !== 32'h0) begin n_fail++; $display("FAIL mid_count: got %0d want 0", enc_count); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        n_assert++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_release: ready %b valid %b want 1 0", bus.in_ready, bus.out_valid); end
        n_assert++; if (bus.out_instr !== 32'h0) begin n_fail++; $display("FAIL mid_out_instr: got %h want 0", bus.out_instr); end
        drive(1, 41, 9, 0, 0, 32'hABCD_E000, 1);
        tick();
        drive(0, 0, 0, 0, 0, 32'h0, 0);
        n_assert++; if (bus.out_instr !== 32'hABCD_E4B7) begin n_fail++; $display("FAIL mid_lui: got %h want abcde4b7", bus.out_instr); end
        n_assert++; if (enc_count !== 32'd1) begin n_fail++; $display("FAIL mid_count_after: got %0d want 1", enc_count); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_illegal_flush();
        test_random();
        test_reset_midburst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
